// File: rtl/async_fifo_if.sv
// async_fifo_if: producer-side and consumer-side token handshakes of async_fifo.
// master is the FIFO's view; slave is the attached producer/consumer environment.
interface async_fifo_if #(
    parameter int data_width = 32,
    parameter int depth = 4
);
    logic req_l;
    logic ack_l;
    logic [data_width-1:0] din;
    logic req_r;
    logic ack_r;
    logic [data_width-1:0] dout;
    logic [$clog2(depth):0] count;
    modport master (output req_l, ack_r, dout, count, input ack_l, din, req_r);
    modport slave (input req_l, ack_r, dout, count, output ack_l, din, req_r);
endinterface

// File: rtl/async_fifo.sv
// async_fifo: single-clock token FIFO between a request/ack producer and consumer.
// Define ASYNC_FIFO_BYPASS_EN to forward din straight to dout when the FIFO is empty.
module async_fifo #(
    parameter int data_width = 32,
    parameter int depth = 4
) (
    input logic clk,
    input logic rst,
    async_fifo_if.master bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full = cw'(depth);

    logic [data_width-1:0] mem_q [depth];
    logic [aw-1:0] wr_ptr_q, rd_ptr_q;
    logic [cw-1:0] count_q, count_d;
    logic req_l_q, req_l_d, ack_r_q, ack_r_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic wr_en, rd_en, byp;

    always_comb begin
        byp = 1'b0;
`ifdef ASYNC_FIFO_BYPASS_EN
        byp = count_q == '0 && bus.ack_l && bus.req_r && !ack_r_q;
`endif
        wr_en = bus.ack_l && count_q != full && !byp;
        rd_en = bus.req_r && !ack_r_q && count_q != '0;
        count_d = count_q + cw'(wr_en) - cw'(rd_en);
        // an accepted or ignored ack_l always forces one idle request cycle
        req_l_d = !bus.ack_l && count_d != full;
        ack_r_d = rd_en || byp;
        dout_d = byp ? bus.din : rd_en ? mem_q[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            req_l_q <= 1'b0;
            ack_r_q <= 1'b0;
            dout_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + aw'(wr_en);
            rd_ptr_q <= rd_ptr_q + aw'(rd_en);
            count_q <= count_d;
            req_l_q <= req_l_d;
            ack_r_q <= ack_r_d;
            dout_q <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.din;
    end

    assign bus.req_l = req_l_q;
    assign bus.ack_r = ack_r_q;
    assign bus.dout = dout_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed checks of async_fifo handshakes, ordering, latency and reset.
module tb_async_fifo;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    logic stop = 1'b0;

    async_fifo_if #(.data_width(32), .depth(4)) f();
    async_fifo #(.data_width(32), .depth(4)) dut (.clk(clk), .rst(rst), .bus(f));

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        while (f.req_l !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout req_l=%b required 1", f.req_l);
        end
        f.ack_l = 1'b1;
        f.din = v;
        tick();
        f.ack_l = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (f.req_l !== 1'b0 || f.ack_r !== 1'b0 || f.dout !== 32'd0 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL reset_state req_l=%b ack_r=%b dout=%0d count=%0d required 0 0 0 0", f.req_l, f.ack_r, f.dout, f.count);
        end
        tick();
        rst = 1'b1;
        tick();
        tests++;
        if (f.req_l !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_req_l got %b required 1", f.req_l);
        end
    endtask

    task automatic test_fill();
        for (int i = 10; i < 14; i++) send(32'(i));
        tests++;
        if (f.count !== 3'd4 || f.req_l !== 1'b0) begin
            fails++;
            $display("FAIL fill_count count=%0d req_l=%b required 4 0", f.count, f.req_l);
        end
        tick();
        tests++;
        if (f.req_l !== 1'b0 || f.ack_r !== 1'b0) begin
            fails++;
            $display("FAIL fill_req_low req_l=%b ack_r=%b required 0 0", f.req_l, f.ack_r);
        end
        f.ack_l = 1'b1;
        f.din = 32'd14;
        tick();
        f.ack_l = 1'b0;
        tests++;
        if (f.count !== 3'd4) begin
            fails++;
            $display("FAIL fill_overflow count=%0d required 4", f.count);
        end
    endtask

    task automatic test_drain();
        int got = 0;
        logic prev = 1'b0;
        f.req_r = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            tick();
            if (f.ack_r === 1'b1) begin
                tests++;
                if (f.dout !== 32'(10 + got) || prev) begin
                    fails++;
                    $display("FAIL drain_token%0d dout=%0d prev_ack=%b required %0d 0", got, f.dout, prev, 10 + got);
                end
                if (got == 0) begin
                    tests++;
                    if (f.req_l !== 1'b1) begin
                        fails++;
                        $display("FAIL drain_req_l got %b required 1", f.req_l);
                    end
                end
                got++;
            end
            prev = f.ack_r;
        end
        f.req_r = 1'b0;
        tests++;
        if (got != 4 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL drain_done reads=%0d count=%0d required 4 0", got, f.count);
        end
        tick();
        tick();
        tests++;
        if (f.dout !== 32'd13 || f.ack_r !== 1'b0) begin
            fails++;
            $display("FAIL drain_hold dout=%0d ack_r=%b required 13 0", f.dout, f.ack_r);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] want [2];
        int got = 0;
        want[0] = 32'd2;
        want[1] = 32'd7;
        send(32'd1);
        send(32'd2);
        tick();
        tests++;
        if (f.count !== 3'd2 || f.req_l !== 1'b1) begin
            fails++;
            $display("FAIL simul_setup count=%0d req_l=%b required 2 1", f.count, f.req_l);
        end
        f.ack_l = 1'b1;
        f.din = 32'd7;
        f.req_r = 1'b1;
        tick();
        f.ack_l = 1'b0;
        tests++;
        if (f.count !== 3'd2 || f.ack_r !== 1'b1 || f.dout !== 32'd1) begin
            fails++;
            $display("FAIL simul_edge count=%0d ack_r=%b dout=%0d required 2 1 1", f.count, f.ack_r, f.dout);
        end
        for (int c = 0; c < 10 && got < 2; c++) begin
            tick();
            if (f.ack_r === 1'b1) begin
                tests++;
                if (f.dout !== want[got]) begin
                    fails++;
                    $display("FAIL simul_order%0d dout=%0d required %0d", got, f.dout, want[got]);
                end
                got++;
            end
        end
        f.req_r = 1'b0;
        tests++;
        if (got != 2 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL simul_done reads=%0d count=%0d required 2 0", got, f.count);
        end
        tick();
    endtask

    task automatic test_latency();
        tick();
        f.req_r = 1'b1;
        f.ack_l = 1'b1;
        f.din = 32'hA5;
        tick();
        f.ack_l = 1'b0;
`ifdef ASYNC_FIFO_BYPASS_EN
        tests++;
        if (f.ack_r !== 1'b1 || f.dout !== 32'hA5 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL latency_bypass ack_r=%b dout=%h count=%0d required 1 a5 0", f.ack_r, f.dout, f.count);
        end
        tick();
        tests++;
        if (f.ack_r !== 1'b0) begin
            fails++;
            $display("FAIL latency_bypass_pulse ack_r=%b required 0", f.ack_r);
        end
`else
        tests++;
        if (f.ack_r !== 1'b0 || f.count !== 3'd1) begin
            fails++;
            $display("FAIL latency_early ack_r=%b count=%0d required 0 1", f.ack_r, f.count);
        end
        tick();
        tests++;
        if (f.ack_r !== 1'b1 || f.dout !== 32'hA5 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL latency_read ack_r=%b dout=%h count=%0d required 1 a5 0", f.ack_r, f.dout, f.count);
        end
`endif
        f.req_r = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int got = 0;
        for (int i = 20; i < 23; i++) send(32'(i));
        tests++;
        if (f.count !== 3'd3) begin
            fails++;
            $display("FAIL midreset_setup count=%0d required 3", f.count);
        end
        f.ack_l = 1'b1;
        f.din = 32'd99;
        #2 rst = 1'b0;
        #1;
        tests++;
        if (f.req_l !== 1'b0 || f.ack_r !== 1'b0 || f.dout !== 32'd0 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL midreset_async req_l=%b ack_r=%b dout=%0d count=%0d required 0 0 0 0", f.req_l, f.ack_r, f.dout, f.count);
        end
        f.ack_l = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tests++;
        if (f.req_l !== 1'b1 || f.count !== 3'd0) begin
            fails++;
            $display("FAIL midreset_release req_l=%b count=%0d required 1 0", f.req_l, f.count);
        end
        f.req_r = 1'b1;
        send(32'd55);
        for (int c = 0; c < 10 && got == 0; c++) begin
            if (f.ack_r === 1'b1) begin
                tests++;
                got = 1;
                if (f.dout !== 32'd55) begin
                    fails++;
                    $display("FAIL midreset_first dout=%0d required 55", f.dout);
                end
            end else tick();
        end
        f.req_r = 1'b0;
        tests++;
        if (got != 1) begin
            fails++;
            $display("FAIL midreset_noread reads=%0d required 1", got);
        end
        tick();
    endtask

    task automatic test_wrap();
        int exp_v = 0;
        stop = 1'b0;
        f.req_r = 1'b1;
        fork
            begin
                for (int i = 0; i < 5000 && !stop; i++) send(32'(i));
            end
            begin
                for (int c = 0; c < 30000 && exp_v < 5000; c++) begin
                    tick();
                    if (f.ack_r === 1'b1) begin
                        tests++;
                        if (f.dout !== 32'(exp_v)) begin
                            fails++;
                            $display("FAIL wrap_token dout=%0d required %0d", f.dout, exp_v);
                        end
                        exp_v++;
                    end
                end
                stop = 1'b1;
            end
        join
        f.req_r = 1'b0;
        tests++;
        if (exp_v != 5000) begin
            fails++;
            $display("FAIL wrap_total reads=%0d required 5000", exp_v);
        end
    endtask

    initial begin
        rst = 1'b0;
        f.ack_l = 1'b0;
        f.din = '0;
        f.req_r = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_latency();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
